// File: rtl/cache_l1_controller_pkg.sv
// Shared types and default widths for the L1 cache sequencing controller.
package cache_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned STAT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    FILL      = 3'd3,
    INSTALL   = 3'd4,
    RESPOND   = 3'd5
  } ctrl_state_e;

endpackage

// File: rtl/cache_l1_controller_if.sv
// CPU, cache-array and memory bus signals of the L1 controller; master is the controller side.
interface cache_l1_controller_if
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned STAT_W = STAT_W_DEF
);
  logic              cpu_req_in;
  logic              cpu_we_in;
  logic [ADDR_W-1:0] cpu_addr_in;
  logic [DATA_W-1:0] cpu_wdata_in;
  logic              cpu_ack_out;
  logic [DATA_W-1:0] cpu_rdata_out;
  logic              busy_out;

  logic              cache_lookup_out;
  logic [ADDR_W-1:0] cache_addr_out;
  logic              cache_hit_in;
  logic [DATA_W-1:0] cache_rdata_in;
  logic              victim_dirty_in;
  logic [ADDR_W-1:0] victim_addr_in;
  logic [DATA_W-1:0] victim_data_in;
  logic              cache_write_out;
  logic              cache_fill_out;
  logic              cache_fill_dirty_out;
  logic [DATA_W-1:0] cache_wdata_out;

  logic              mem_req_out;
  logic              mem_we_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [DATA_W-1:0] mem_wdata_out;
  logic [DATA_W-1:0] mem_rdata_in;
  logic              mem_ready_in;

  logic [STAT_W-1:0] hit_count_out;
  logic [STAT_W-1:0] miss_count_out;
  logic [STAT_W-1:0] wb_count_out;

  modport master (
    input  cpu_req_in, cpu_we_in, cpu_addr_in, cpu_wdata_in,
    output cpu_ack_out, cpu_rdata_out, busy_out,
    output cache_lookup_out, cache_addr_out,
    input  cache_hit_in, cache_rdata_in, victim_dirty_in, victim_addr_in, victim_data_in,
    output cache_write_out, cache_fill_out, cache_fill_dirty_out, cache_wdata_out,
    output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
    input  mem_rdata_in, mem_ready_in,
    output hit_count_out, miss_count_out, wb_count_out
  );

  modport slave (
    output cpu_req_in, cpu_we_in, cpu_addr_in, cpu_wdata_in,
    input  cpu_ack_out, cpu_rdata_out, busy_out,
    input  cache_lookup_out, cache_addr_out,
    output cache_hit_in, cache_rdata_in, victim_dirty_in, victim_addr_in, victim_data_in,
    input  cache_write_out, cache_fill_out, cache_fill_dirty_out, cache_wdata_out,
    input  mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
    output mem_rdata_in, mem_ready_in,
    input  hit_count_out, miss_count_out, wb_count_out
  );

endinterface

// File: rtl/cache_l1_controller_stats.sv
// Saturating hit/miss/writeback counters; only built when CACHE_CTRL_STATS_EN is defined.
`ifdef CACHE_CTRL_STATS_EN
module cache_ctrl_stats #(
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hit_inc,
  input  logic              miss_inc,
  input  logic              wb_inc,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count,
  output logic [STAT_W-1:0] wb_count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (hit_inc && (hit_count != '1))
        hit_count <= hit_count + STAT_W'(1);
      if (miss_inc && (miss_count != '1))
        miss_count <= miss_count + STAT_W'(1);
      if (wb_inc && (wb_count != '1))
        wb_count <= wb_count + STAT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/cache_l1_controller.sv
// L1 sequencing FSM: lookup, dirty-victim writeback, fill, install, respond (write-allocate, write-back).
// Optional statistics counters are enabled with CACHE_CTRL_STATS_EN.
module cache_l1_controller
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned STAT_W = STAT_W_DEF
) (
  input  logic                  clock_in,
  input  logic                  reset_n_in,
  cache_l1_controller_if.master bus
);

  ctrl_state_e       state_q, state_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] victim_addr_q;
  logic [DATA_W-1:0] victim_data_q;
  logic [DATA_W-1:0] fill_data_q;
  logic [DATA_W-1:0] rdata_q;

  logic in_lookup;
  logic lookup_hit;
  logic wb_done;

  assign in_lookup  = (state_q == LOOKUP);
  assign lookup_hit = in_lookup && bus.cache_hit_in;
  assign wb_done    = (state_q == WRITEBACK) && bus.mem_ready_in;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.cpu_req_in) state_d = LOOKUP;
      LOOKUP: begin
        if (lookup_hit)               state_d = RESPOND;
        else if (bus.victim_dirty_in) state_d = WRITEBACK;
        else                          state_d = FILL;
      end
      WRITEBACK: if (wb_done) state_d = FILL;
      FILL:      if (bus.mem_ready_in) state_d = INSTALL;
      INSTALL:   state_d = RESPOND;
      RESPOND:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // rdata_q is cleared on accept so a write transaction responds with zero.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      victim_addr_q <= '0;
      victim_data_q <= '0;
      fill_data_q   <= '0;
      rdata_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cpu_req_in) begin
            we_q    <= bus.cpu_we_in;
            addr_q  <= bus.cpu_addr_in;
            wdata_q <= bus.cpu_wdata_in;
            rdata_q <= '0;
          end
        end
        LOOKUP: begin
          if (lookup_hit && !we_q) rdata_q <= bus.cache_rdata_in;
          if (!bus.cache_hit_in && bus.victim_dirty_in) begin
            victim_addr_q <= bus.victim_addr_in;
            victim_data_q <= bus.victim_data_in;
          end
        end
        FILL:    if (bus.mem_ready_in) fill_data_q <= bus.mem_rdata_in;
        INSTALL: if (!we_q) rdata_q <= fill_data_q;
        default: ;
      endcase
    end
  end

  // Outputs decode the registered state; only the lookup write strobe also looks at cache_hit_in.
  always_comb begin
    bus.cpu_ack_out          = 1'b0;
    bus.cpu_rdata_out        = '0;
    bus.busy_out             = (state_q != IDLE);
    bus.cache_lookup_out     = 1'b0;
    bus.cache_addr_out       = '0;
    bus.cache_write_out      = 1'b0;
    bus.cache_fill_out       = 1'b0;
    bus.cache_fill_dirty_out = 1'b0;
    bus.cache_wdata_out      = '0;
    bus.mem_req_out          = 1'b0;
    bus.mem_we_out           = 1'b0;
    bus.mem_addr_out         = '0;
    bus.mem_wdata_out        = '0;
    case (state_q)
      LOOKUP: begin
        bus.cache_lookup_out = 1'b1;
        bus.cache_addr_out   = addr_q;
        if (bus.cache_hit_in && we_q) begin
          bus.cache_write_out = 1'b1;
          bus.cache_wdata_out = wdata_q;
        end
      end
      WRITEBACK: begin
        bus.mem_req_out   = 1'b1;
        bus.mem_we_out    = 1'b1;
        bus.mem_addr_out  = victim_addr_q;
        bus.mem_wdata_out = victim_data_q;
      end
      FILL: begin
        bus.mem_req_out  = 1'b1;
        bus.mem_addr_out = addr_q;
      end
      INSTALL: begin
        bus.cache_fill_out       = 1'b1;
        bus.cache_addr_out       = addr_q;
        bus.cache_fill_dirty_out = we_q;
        bus.cache_wdata_out      = we_q ? wdata_q : fill_data_q;
      end
      RESPOND: begin
        bus.cpu_ack_out   = 1'b1;
        bus.cpu_rdata_out = rdata_q;
      end
      default: ;
    endcase
  end

`ifdef CACHE_CTRL_STATS_EN
  cache_ctrl_stats #(
    .STAT_W(STAT_W)
  ) u_stats (
    .clk        (clock_in),
    .rst_n      (reset_n_in),
    .hit_inc    (lookup_hit),
    .miss_inc   (in_lookup && !bus.cache_hit_in),
    .wb_inc     (wb_done),
    .hit_count  (bus.hit_count_out),
    .miss_count (bus.miss_count_out),
    .wb_count   (bus.wb_count_out)
  );
`else
  assign bus.hit_count_out  = {STAT_W{1'b0}};
  assign bus.miss_count_out = {STAT_W{1'b0}};
  assign bus.wb_count_out   = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_cache_l1_controller.sv
// Scoreboard bench: stimulus pushes expected CPU/cache/memory events, negedge monitors pop and compare.
module tb_cache_l1_controller;

  localparam int unsigned AW  = 5;
  localparam int unsigned DW  = 8;
  localparam int unsigned SW  = 4;
  localparam int          SAT = (1 << SW) - 1;
`ifdef CACHE_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct { logic [DW-1:0] rdata; int lat; int issue; } cpu_exp_t;
  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } mem_exp_t;
  typedef struct { logic fill; logic dirty; logic [AW-1:0] addr; logic [DW-1:0] data; } cache_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   cur_wb_lat = 1;
  int   cur_fill_lat = 1;
  int   m_hit = 0, m_miss = 0, m_wb = 0;
  logic [DW-1:0] ref_mem [32];

  cpu_exp_t      cpu_q[$];
  mem_exp_t      mem_q[$];
  cache_exp_t    cache_q[$];
  logic [AW-1:0] lk_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_l1_controller_if #(.ADDR_W(AW), .DATA_W(DW), .STAT_W(SW)) bus ();

  cache_l1_controller #(.ADDR_W(AW), .DATA_W(DW), .STAT_W(SW)) dut (
    .clock_in   (clk),
    .reset_n_in (rst_n),
    .bus        (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.cpu_ack_out, bus.cpu_rdata_out, bus.busy_out, bus.cache_lookup_out,
                bus.cache_addr_out, bus.cache_write_out, bus.cache_fill_out,
                bus.cache_fill_dirty_out, bus.cache_wdata_out, bus.mem_req_out,
                bus.mem_we_out, bus.mem_addr_out, bus.mem_wdata_out,
                bus.hit_count_out, bus.miss_count_out, bus.wb_count_out});
  endfunction

  function automatic int sat(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic check_stats();
    chk("hit_count",  64'(bus.hit_count_out),  STATS ? 64'(m_hit)  : 64'd0);
    chk("miss_count", 64'(bus.miss_count_out), STATS ? 64'(m_miss) : 64'd0);
    chk("wb_count",   64'(bus.wb_count_out),   STATS ? 64'(m_wb)   : 64'd0);
  endtask

  // Memory model: returns data after a programmable number of request cycles.
  initial begin : mem_responder
    logic [DW-1:0] phys_mem [32];
    int mcnt;
    mem_exp_t me;
    for (int i = 0; i < 32; i++) phys_mem[i] = 8'(i * 7 + 29);
    bus.mem_ready_in = 1'b0;
    bus.mem_rdata_in = '0;
    mcnt = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_ready_in || !rst_n) begin
        bus.mem_ready_in = 1'b0;
        mcnt = 0;
      end
      if (rst_n && bus.mem_req_out) begin
        mcnt++;
        if (mcnt >= (bus.mem_we_out ? cur_wb_lat : cur_fill_lat)) begin
          if (mem_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mem_unexpected: got we=%0b addr=%0h expected no request",
                     bus.mem_we_out, bus.mem_addr_out);
          end else begin
            me = mem_q.pop_front();
            chk("mem_op", 64'({bus.mem_we_out, bus.mem_addr_out, bus.mem_we_out ? bus.mem_wdata_out : 8'h00}),
                          64'({me.we, me.addr, me.wdata}));
          end
          if (bus.mem_we_out) phys_mem[bus.mem_addr_out] = bus.mem_wdata_out;
          else                bus.mem_rdata_in = phys_mem[bus.mem_addr_out];
          bus.mem_ready_in = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin : cpu_monitor
    cpu_exp_t ce;
    if (rst_n && bus.cpu_ack_out) begin
      if (cpu_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ack_unexpected: got ack expected none");
      end else begin
        ce = cpu_q.pop_front();
        chk("rdata", 64'(bus.cpu_rdata_out), 64'(ce.rdata));
        chk("latency", 64'(cyc - ce.issue), 64'(ce.lat));
      end
    end
  end

  always @(negedge clk) begin : cache_monitor
    cache_exp_t ke;
    logic [AW-1:0] la;
    if (rst_n && bus.cache_lookup_out) begin
      if (lk_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL lookup_unexpected: got addr %0h expected none", bus.cache_addr_out);
      end else begin
        la = lk_q.pop_front();
        chk("lookup_addr", 64'(bus.cache_addr_out), 64'(la));
      end
    end
    if (rst_n && (bus.cache_write_out || bus.cache_fill_out)) begin
      if (cache_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL cache_unexpected: got fill=%0b addr=%0h expected none",
                 bus.cache_fill_out, bus.cache_addr_out);
      end else begin
        ke = cache_q.pop_front();
        chk("cache_op", 64'({bus.cache_fill_out, bus.cache_fill_dirty_out, bus.cache_addr_out, bus.cache_wdata_out}),
                        64'({ke.fill, ke.dirty, ke.addr, ke.data}));
      end
    end
  end

  task automatic do_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic hit, input logic [DW-1:0] hrd, input logic vdirty,
                        input logic [AW-1:0] vaddr, input logic [DW-1:0] vdata,
                        input int wbl, input int fl, input logic drop);
    cpu_exp_t ce;
    mem_exp_t me;
    cache_exp_t ke;
    int n;
    @(negedge clk);
    cur_wb_lat = wbl;
    cur_fill_lat = fl;
    bus.cache_hit_in = hit;
    bus.cache_rdata_in = hrd;
    bus.victim_dirty_in = vdirty;
    bus.victim_addr_in = vaddr;
    bus.victim_data_in = vdata;
    bus.cpu_we_in = we;
    bus.cpu_addr_in = addr;
    bus.cpu_wdata_in = wdata;
    bus.cpu_req_in = 1'b1;
    lk_q.push_back(addr);
    if (hit) begin
      m_hit = sat(m_hit);
      ce.lat = 2;
      ce.rdata = we ? '0 : hrd;
      if (we) begin
        ke.fill = 1'b0; ke.dirty = 1'b0; ke.addr = addr; ke.data = wdata;
        cache_q.push_back(ke);
      end
    end else begin
      m_miss = sat(m_miss);
      if (vdirty) begin
        me.we = 1'b1; me.addr = vaddr; me.wdata = vdata;
        mem_q.push_back(me);
        ref_mem[vaddr] = vdata;
        m_wb = sat(m_wb);
      end
      me.we = 1'b0; me.addr = addr; me.wdata = '0;
      mem_q.push_back(me);
      ke.fill = 1'b1; ke.dirty = we; ke.addr = addr; ke.data = we ? wdata : ref_mem[addr];
      cache_q.push_back(ke);
      ce.rdata = we ? '0 : ref_mem[addr];
      ce.lat = 3 + fl + (vdirty ? wbl : 0);
    end
    ce.issue = cyc;
    cpu_q.push_back(ce);
    @(negedge clk);
    chk("busy", 64'(bus.busy_out), 64'd1);
    if (drop) bus.cpu_req_in = 1'b0;
    n = 0;
    while (!bus.cpu_ack_out && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL ack_timeout: got no ack expected ack within 300 cycles");
      finish_sim();
    end
    bus.cpu_req_in = 1'b0;
  endtask

  task automatic clear_model();
    cpu_q.delete(); mem_q.delete(); cache_q.delete(); lk_q.delete();
    m_hit = 0; m_miss = 0; m_wb = 0;
  endtask

  initial begin : stimulus
    logic we, hit, vd, drop;
    logic [AW-1:0] a;
    int n;
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i * 7 + 29);
    bus.cpu_req_in = 1'b0; bus.cpu_we_in = 1'b0; bus.cpu_addr_in = '0; bus.cpu_wdata_in = '0;
    bus.cache_hit_in = 1'b0; bus.cache_rdata_in = '0; bus.victim_dirty_in = 1'b0;
    bus.victim_addr_in = '0; bus.victim_data_in = '0;

    #1 rst_n = 1'b0;
    #1 chk("reset_outputs", all_outs(), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", all_outs(), 64'd0);

    // Abandon a read miss while memory is still being asked for the fill.
    @(negedge clk);
    cur_fill_lat = 50;
    bus.cache_hit_in = 1'b0; bus.victim_dirty_in = 1'b0;
    bus.cpu_we_in = 1'b0; bus.cpu_addr_in = 5'h1C; bus.cpu_req_in = 1'b1;
    lk_q.push_back(5'h1C);
    n = 0;
    while (!bus.mem_req_out && n < 10) begin @(negedge clk); n++; end
    chk("fill_started", 64'({bus.mem_req_out, bus.mem_we_out, bus.mem_addr_out}), 64'({1'b1, 1'b0, 5'h1C}));
    #2 rst_n = 1'b0;
    #1 chk("async_reset_mid_fill", all_outs(), 64'd0);
    bus.cpu_req_in = 1'b0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_abort", all_outs(), 64'd0);

    do_txn(1'b1, 5'h07, 8'hA5, 1'b1, 8'h00, 1'b0, 5'h00, 8'h00, 1, 1, 1'b1);
    @(negedge clk);
    check_stats();
    do_txn(1'b0, 5'h03, 8'h00, 1'b1, 8'd42, 1'b0, 5'h00, 8'h00, 1, 1, 1'b0);
    do_txn(1'b0, 5'h0A, 8'h00, 1'b0, 8'h00, 1'b0, 5'h00, 8'h00, 1, 3, 1'b0);
    do_txn(1'b1, 5'h11, 8'd7,  1'b0, 8'h00, 1'b1, 5'h04, 8'd55, 2, 2, 1'b0);

    for (int t = 0; t < 80; t++) begin
      we = 1'($urandom); hit = 1'($urandom); vd = 1'($urandom);
      drop = ($urandom_range(3) == 0);
      a = 5'($urandom);
      do_txn(we, a, 8'($urandom), hit, 8'($urandom), vd, a ^ 5'($urandom_range(31, 1)),
             8'($urandom), $urandom_range(4, 1), $urandom_range(4, 1), drop);
    end
    @(negedge clk);
    check_stats();

    #2 rst_n = 1'b0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 17; t++)
      do_txn(1'b0, 5'($urandom), 8'h00, 1'b1, 8'($urandom), 1'b0, 5'h00, 8'h00, 1, 1, 1'b0);
    @(negedge clk);
    check_stats();

    repeat (3) @(negedge clk);
    chk("pending_expectations", 64'(cpu_q.size() + mem_q.size() + cache_q.size() + lk_q.size()), 64'd0);
    finish_sim();
  end

  initial begin : watchdog
    #200000;
    checks++; errors++;
    $display("FAIL watchdog: got timeout expected completion");
    finish_sim();
  end

endmodule
